// File: rtl/btb_predictor_pkg.sv
// +-----------------------------------------------------------------------+
// | rv32i_types : shared branch-prediction types and counter helper      |
// | Rev 1.0                                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

package rv32i_types;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } btb_ctr_t;

   localparam btb_ctr_t BTB_CTR_INIT = CTR_WT;

   function automatic btb_ctr_t ctr_step(input btb_ctr_t c, input logic taken);
      btb_ctr_t r;
      r = c;
      unique case (c)
         CTR_SNT: r = taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: r = taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  r = taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  r = taken ? CTR_ST  : CTR_WT;
         default: r = c;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btb_predictor_array.sv
// +-----------------------------------------------------------------------+
// | btb_array : one-write one-read target store, write-through on match  |
// | Rev 1.0                                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module btb_array #(
   parameter int s_index = 3,
   parameter int width   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [s_index-1:0] windex,
   input  logic [width-1:0]   wdata,
   input  logic [s_index-1:0] rindex,
   output logic [width-1:0]   rdata
);

   localparam int SETS = 2 ** s_index;

   logic [width-1:0] data_q [SETS];
   logic [width-1:0] data_d [SETS];

   always_comb begin
      data_d = data_q;
      if (we) data_d[windex] = wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) data_q[s] <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign rdata = (we && (windex == rindex)) ? wdata : data_q[rindex];

endmodule

`default_nettype wire

// File: rtl/btb_predictor.sv
// +-----------------------------------------------------------------------+
// | btb_predictor : two-way set-associative BTB, IF lookup / EX training |
// | Rev 1.0                                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module btb_predictor
   import rv32i_types::*;
#(
   parameter int s_index = 3,
   parameter int width   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] if_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [width-1:0] pred_target,
   input  logic             ex_valid,
   input  logic [width-1:0] ex_pc,
   input  logic             ex_taken,
   input  logic [width-1:0] ex_target
);

   localparam int SETS  = 2 ** s_index;
   localparam int TAG_W = width - s_index - 2;

   logic [s_index-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0]   if_tag, ex_tag;
   logic               unused_low_bits;

   assign if_idx          = if_pc[s_index+1:2];
   assign if_tag          = if_pc[width-1:s_index+2];
   assign ex_idx          = ex_pc[s_index+1:2];
   assign ex_tag          = ex_pc[width-1:s_index+2];
   assign unused_low_bits = ^{if_pc[1:0], ex_pc[1:0]};

   logic [TAG_W-1:0] tag_q   [2][SETS];
   logic [TAG_W-1:0] tag_d   [2][SETS];
   logic             valid_q [2][SETS];
   logic             valid_d [2][SETS];
   btb_ctr_t         ctr_q   [2][SETS];
   btb_ctr_t         ctr_d   [2][SETS];
   logic             lru_q   [SETS];
   logic             lru_d   [SETS];

   logic             upd;
   logic             ex_hit0, ex_hit1, ex_way;
   logic [1:0]       tgt_we;
   logic [TAG_W-1:0] ns_tag   [2];
   logic             ns_valid [2];
   btb_ctr_t         ns_ctr   [2];
   logic             ns_lru;

   // Reset dominates a coincident update.
   assign upd = ex_valid & ~rst;

   // Post-update view of the EX set; feeds both the commit and the lookup bypass.
   always_comb begin
      ex_hit0 = valid_q[0][ex_idx] && (tag_q[0][ex_idx] == ex_tag);
      ex_hit1 = !ex_hit0 && valid_q[1][ex_idx] && (tag_q[1][ex_idx] == ex_tag);
      for (int w = 0; w < 2; w++) begin
         ns_tag[w]   = tag_q[w][ex_idx];
         ns_valid[w] = valid_q[w][ex_idx];
         ns_ctr[w]   = ctr_q[w][ex_idx];
      end
      ns_lru = lru_q[ex_idx];
      tgt_we = 2'b00;
      ex_way = 1'b0;
      if (ex_hit0 || ex_hit1) begin
         ex_way         = ex_hit1;
         ns_ctr[ex_way] = ctr_step(ctr_q[ex_way][ex_idx], ex_taken);
         tgt_we[ex_way] = ex_taken;
         ns_lru         = ~ex_way;
      end else if (ex_taken) begin
         if (!valid_q[0][ex_idx])      ex_way = 1'b0;
         else if (!valid_q[1][ex_idx]) ex_way = 1'b1;
         else                          ex_way = lru_q[ex_idx];
         ns_tag[ex_way]   = ex_tag;
         ns_valid[ex_way] = 1'b1;
         ns_ctr[ex_way]   = BTB_CTR_INIT;
         tgt_we[ex_way]   = 1'b1;
         ns_lru           = ~ex_way;
      end
      if (!upd) tgt_we = 2'b00;
   end

   always_comb begin
      tag_d   = tag_q;
      valid_d = valid_q;
      ctr_d   = ctr_q;
      lru_d   = lru_q;
      if (upd) begin
         for (int w = 0; w < 2; w++) begin
            tag_d[w][ex_idx]   = ns_tag[w];
            valid_d[w][ex_idx] = ns_valid[w];
            ctr_d[w][ex_idx]   = ns_ctr[w];
         end
         lru_d[ex_idx] = ns_lru;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < SETS; s++) begin
               tag_q[w][s]   <= '0;
               valid_q[w][s] <= 1'b0;
               ctr_q[w][s]   <= CTR_SNT;
            end
         end
         for (int s = 0; s < SETS; s++) lru_q[s] <= 1'b0;
      end else begin
         tag_q   <= tag_d;
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
         lru_q   <= lru_d;
      end
   end

   logic [width-1:0] tgt_rd [2];

   for (genvar w = 0; w < 2; w++) begin : g_way
      btb_array #(
         .s_index (s_index),
         .width   (width)
      ) u_array (
         .clk    (clk),
         .rst    (rst),
         .we     (tgt_we[w]),
         .windex (ex_idx),
         .wdata  (ex_target),
         .rindex (if_idx),
         .rdata  (tgt_rd[w])
      );
   end

   logic             bypass;
   logic [TAG_W-1:0] lk_tag   [2];
   logic             lk_valid [2];
   btb_ctr_t         lk_ctr   [2];
   logic             lk_hit0, lk_hit1;
   btb_ctr_t         sel_ctr;

   assign bypass = upd && (ex_idx == if_idx);

   always_comb begin
      for (int w = 0; w < 2; w++) begin
         lk_tag[w]   = bypass ? ns_tag[w]   : tag_q[w][if_idx];
         lk_valid[w] = bypass ? ns_valid[w] : valid_q[w][if_idx];
         lk_ctr[w]   = bypass ? ns_ctr[w]   : ctr_q[w][if_idx];
      end
      lk_hit0     = lk_valid[0] && (lk_tag[0] == if_tag);
      lk_hit1     = !lk_hit0 && lk_valid[1] && (lk_tag[1] == if_tag);
      sel_ctr     = lk_hit0 ? lk_ctr[0] : lk_ctr[1];
      pred_hit    = lk_hit0 || lk_hit1;
      pred_taken  = pred_hit && sel_ctr[1];
      pred_target = pred_taken ? (lk_hit0 ? tgt_rd[0] : tgt_rd[1])
                               : if_pc + width'(4);
   end

endmodule

`default_nettype wire

// File: tb/tb_btb_predictor.sv
// +-----------------------------------------------------------------------+
// | tb_btb_predictor : directed stimulus with queued expected lookups    |
// | Rev 1.0                                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_btb_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid, ex_taken;
   logic [31:0] ex_pc, ex_target;

   btb_predictor #(.s_index(3), .width(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .if_pc       (if_pc),
      .pred_hit    (pred_hit),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .ex_valid    (ex_valid),
      .ex_pc       (ex_pc),
      .ex_taken    (ex_taken),
      .ex_target   (ex_target)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic        hit;
      logic        taken;
      logic [31:0] tgt;
   } exp_t;

   exp_t exp_q[$];
   logic look_v = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // One cycle of stimulus; a lookup request pushes its expected response.
   task automatic step(input logic r, input logic ev, input logic [31:0] epc,
                       input logic et, input logic [31:0] etgt,
                       input logic lv, input logic [31:0] lpc,
                       input logic eh, input logic etk, input logic [31:0] etg);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = r;
      ex_valid  = ev;
      ex_pc     = epc;
      ex_taken  = et;
      ex_target = etgt;
      if_pc     = lpc;
      if (lv) begin
         e.pc = lpc; e.hit = eh; e.taken = etk; e.tgt = etg;
         exp_q.push_back(e);
      end
      look_v = lv;
   endtask

   always @(negedge clk) begin
      if (look_v) begin
         exp_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL lookup pc=%h: no expected entry queued", if_pc);
         end else begin
            e = exp_q.pop_front();
            if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.tgt) begin
               errors++;
               $display("FAIL lookup pc=%h: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                        e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0; if_pc = '0;
      repeat (2) @(posedge clk);
      //   rst  ev   ex_pc         et   ex_tgt        lv   if_pc         hit  tkn  target
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000010, 1'b0, 1'b0, 32'h00000014);
      // not-taken on an empty set never allocates
      step(1'b0, 1'b1, 32'h70,     1'b0, 32'h700,     1'b1, 32'h00000070, 1'b0, 1'b0, 32'h00000074);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000070, 1'b0, 1'b0, 32'h00000074);
      // allocate with write-through lookup, then steady-state hit
      step(1'b0, 1'b1, 32'h10,     1'b1, 32'h100,     1'b1, 32'h00000010, 1'b1, 1'b1, 32'h00000100);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000010, 1'b1, 1'b1, 32'h00000100);
      // 10 -> 01 -> 00
      step(1'b0, 1'b1, 32'h10,     1'b0, 32'h0,       1'b1, 32'h00000010, 1'b1, 1'b0, 32'h00000014);
      step(1'b0, 1'b1, 32'h10,     1'b0, 32'h0,       1'b1, 32'h00000010, 1'b1, 1'b0, 32'h00000014);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000010, 1'b1, 1'b0, 32'h00000014);
      // 00 -> 01 -> 10 -> 11, then one not-taken leaves 10 (still taken)
      step(1'b0, 1'b1, 32'h10,     1'b1, 32'h100,     1'b1, 32'h00000010, 1'b1, 1'b0, 32'h00000014);
      step(1'b0, 1'b1, 32'h10,     1'b1, 32'h100,     1'b1, 32'h00000010, 1'b1, 1'b1, 32'h00000100);
      step(1'b0, 1'b1, 32'h10,     1'b1, 32'h100,     1'b1, 32'h00000010, 1'b1, 1'b1, 32'h00000100);
      step(1'b0, 1'b1, 32'h10,     1'b0, 32'h0,       1'b1, 32'h00000010, 1'b1, 1'b1, 32'h00000100);
      // alias set 4: way1 fills, then LRU (way0) is evicted
      step(1'b0, 1'b1, 32'h30,     1'b1, 32'h200,     1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000030, 1'b1, 1'b1, 32'h00000200);
      step(1'b0, 1'b1, 32'h50,     1'b1, 32'h300,     1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000010, 1'b0, 1'b0, 32'h00000014);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000030, 1'b1, 1'b1, 32'h00000200);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000050, 1'b1, 1'b1, 32'h00000300);
      // fall-through wraps modulo 2**32
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h00000000);
      // reset with a coincident taken update: nothing survives
      step(1'b1, 1'b1, 32'h90,     1'b1, 32'h400,     1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000090, 1'b0, 1'b0, 32'h00000094);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000030, 1'b0, 1'b0, 32'h00000034);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b1, 32'h00000050, 1'b0, 1'b0, 32'h00000054);
      step(1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected lookups left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
